// File: rtl/fir_da_pkg.sv
// Shared sizing and FSM encoding for the FIR distributed-arithmetic path.
// Used by the LUT loader and by fir_filter's DA core.
package fir_da_pkg;

  localparam int COEF_W       = 16;
  localparam int CIN_W        = 20;
  localparam int TAPS_PER_LUT = 8;
  localparam int NUM_LUTS     = 8;

  localparam int LUT_W   = $clog2(NUM_LUTS);
  localparam int TAP_W   = $clog2(TAPS_PER_LUT);
  localparam int ENT_W   = TAPS_PER_LUT;
  localparam int CADDR_W = LUT_W + ENT_W;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    DONE
  } da_state_e;

  typedef logic signed [COEF_W-1:0] coef_t;

endpackage

// File: rtl/da_lut_sum.sv
// Masked signed adder: sums the taps selected by the bits of a LUT index.
// Purely combinational; the loader registers the result.
module da_lut_sum
  import fir_da_pkg::*;
(
  input  coef_t                   creg [TAPS_PER_LUT],
  input  logic [ENT_W-1:0]        entry,
  output logic signed [CIN_W-1:0] sum
);

  always_comb begin
    sum = '0;
    for (int k = 0; k < TAPS_PER_LUT; k++) begin
      if (entry[k]) begin
        sum = sum + {{(CIN_W-COEF_W){creg[k][COEF_W-1]}}, creg[k]};
      end
    end
  end

endmodule

// File: rtl/da_lut_loader.sv
// Collects coefficients per LUT group and streams every partial-sum
// entry into fir_filter over CIN/CADDR/CLOAD, one entry per clock.
module da_lut_loader
  import fir_da_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               cfg_start,
  input  logic [COEF_W-1:0]  coef_in,
  input  logic               coef_valid,
  output logic               coef_ready,
  output logic [CIN_W-1:0]   CIN,
  output logic [CADDR_W-1:0] CADDR,
  output logic               CLOAD,
  output logic               busy,
  output logic               load_done
);

  da_state_e state, state_nx;

  logic [LUT_W-1:0] lut;
  logic [TAP_W-1:0] tap;
  logic [ENT_W-1:0] entry;
  coef_t            creg [TAPS_PER_LUT];

  logic signed [CIN_W-1:0] sum;
  logic start, accept;
  logic last_tap, last_ent, last_lut;

  assign start    = (state == IDLE) && cfg_start;
  assign accept   = coef_valid && coef_ready;
  assign last_tap = tap == TAP_W'(TAPS_PER_LUT-1);
  assign last_ent = &entry;
  assign last_lut = lut == LUT_W'(NUM_LUTS-1);

  da_lut_sum u_sum (
    .creg  (creg),
    .entry (entry),
    .sum   (sum)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (cfg_start) state_nx = COLLECT;
      COLLECT: if (accept && last_tap) state_nx = WRITE;
      WRITE:   if (last_ent) state_nx = last_lut ? DONE : COLLECT;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    coef_ready = (state == COLLECT);
  end

  // tap and entry wrap to 0 on their own at group boundaries
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lut   <= '0;
      tap   <= '0;
      entry <= '0;
      for (int k = 0; k < TAPS_PER_LUT; k++) creg[k] <= '0;
    end else begin
      if (start) begin
        lut <= '0;
        tap <= '0;
      end
      if (accept) begin
        creg[tap] <= coef_in;
        tap       <= tap + 1'b1;
        if (last_tap) entry <= '0;
      end
      if (state == WRITE) begin
        entry <= entry + 1'b1;
        if (last_ent && !last_lut) lut <= lut + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      CLOAD     <= 1'b0;
      CADDR     <= '0;
      CIN       <= '0;
      load_done <= 1'b0;
      busy      <= 1'b0;
    end else begin
      CLOAD     <= (state == WRITE);
      load_done <= (state == DONE);
      if (state == WRITE) begin
        CADDR <= {lut, entry};
        CIN   <= sum;
      end
      if (start)          busy <= 1'b1;
      else if (load_done) busy <= 1'b0;
    end
  end

endmodule

// File: doc/da_lut_loader.md
Name: da_lut_loader

Overview:
- Upstream configuration stage for fir_filter's distributed-arithmetic core.
- Accepts the raw 64-tap coefficient set as a ready/valid stream of 16-bit signed words.
- Computes every DA partial-sum LUT entry (8 LUTs x 256 entries) and drives them into the filter over CIN/CADDR/CLOAD, one entry per clock.
- Asserts busy while loading so the system holds the filter's valid_in low.

Parameters:
- COEF_W, 16, coefficient width (signed, two's complement)
- CIN_W, 20, LUT entry width; must be >= COEF_W+3
- TAPS_PER_LUT, 8, taps per LUT; LUT depth = 2^TAPS_PER_LUT = 256
- NUM_LUTS, 8, number of LUTs; CADDR width = log2(NUM_LUTS)+TAPS_PER_LUT = 11

Ports:
- clk  in  1  single clock
- resetn  in  1  asynchronous active-low reset
- cfg_start  in  1  one-cycle pulse; begins a full reload (honoured in IDLE only)
- coef_in  in  COEF_W  coefficient word, tap order 0..63
- coef_valid  in  1  coef_in valid
- coef_ready  out  1  loader accepts coef_in this cycle
- CIN  out  CIN_W  LUT entry data to fir_filter
- CADDR  out  11  LUT address {lut[2:0], entry[7:0]}
- CLOAD  out  1  write strobe, one entry per cycle
- busy  out  1  high from accepted cfg_start until the done pulse, inclusive
- load_done  out  1  one-cycle pulse after the last entry is written

Behaviour:
- Clocking and reset: one clock; reset is asynchronous, active-low, on resetn.
- Reset values: all outputs 0; state IDLE; counters 0; coefficient registers 0.
- FSM states:
  - IDLE: cfg_start=1 -> COLLECT, with lut=0 and tap=0; busy goes high on the next edge.
  - COLLECT: coef_ready=1. Each coef_valid&coef_ready stores coef_in into creg[tap] and increments tap. The accept with tap==7 -> WRITE, entry=0.
  - WRITE: coef_ready=0. Registered outputs each cycle: CLOAD=1, CADDR={lut,entry}, CIN=S(entry). entry increments. At entry==255, the next state is chosen by lut:
    - lut<7: lut++, tap=0 -> COLLECT.
    - lut==7: -> DONE.
  - DONE: load_done=1 for one cycle; busy=0 on the following edge -> IDLE.
- Partial-sum arithmetic: S(e) = sum over k=0..7 of (e[k] ? sext(creg[k]) : 0), computed in CIN_W bits. Bit k of the entry index selects tap lut*8+k. Range is -2^18..(2^18-8); it never overflows 20 bits.
- Timing:
  - First CLOAD is registered on the edge after the 8th accept of a group.
  - CLOAD stays high for exactly 256 consecutive cycles per group. CLOAD=0 in every other state. CIN/CADDR hold their last value when CLOAD=0.
  - Minimum total load time is 8*(8+256)+1 cycles after cfg_start.
- Backpressure: coef_valid may drop at any time in COLLECT. There are no gaps inside a WRITE burst. Coefficients presented outside COLLECT are not accepted.
- cfg_start when not in IDLE: ignored. No restart, no effect on counters.
- Reset mid-operation: returns to IDLE at once. CLOAD drops asynchronously. A partially written LUT set is invalid until a full reload completes.
- Simultaneous cfg_start and coef_valid in IDLE: the coefficient is not accepted (coef_ready=0 in IDLE).

Decomposition:
- Shared package: fir_da_pkg holds COEF_W, CIN_W, TAPS_PER_LUT, NUM_LUTS, the CADDR field widths, and the FSM state encoding (IDLE, COLLECT, WRITE, DONE). fir_filter's DA core uses the same package.
- One sub-module, da_lut_sum: a combinational masked 8-input signed adder (creg[0..7], entry[7:0] -> S). It is instantiated once, and its output is registered in da_lut_loader.

Test Plan:
- All 64 coefs = 1, coef_valid held high -> 2048 CLOAD cycles; CIN = popcount(entry[7:0]) at every CADDR; load_done one cycle after CADDR=0x7FF; busy drops on the next edge.
- All coefs = -32768 (0x8000) -> at CADDR {g,0xFF}, CIN = 0xC0000; at CADDR {g,0x00}, CIN = 0; at CADDR {g,0x01}, CIN = 0xF8000.
- Single impulse (tap 13 = 0x1234, others 0) -> LUT 1 entries with bit 5 set read 0x01234; all other entries in all LUTs read 0.
- coef_valid toggled 1-0-1-0 in COLLECT -> exactly 8 accepts per group, coef_ready=0 throughout each WRITE, CLOAD bursts unbroken at 256 cycles.
- cfg_start pulsed again during LUT 3's WRITE -> ignored; sequence and total cycle count unchanged.
- resetn=0 at CADDR=0x2A0 mid-WRITE -> CLOAD/busy go 0 immediately; after release, a new cfg_start reload begins again at CADDR=0x000.
